// File: rtl/nes_cpu_pkg.sv
// Shared types and constants for the 2A03 CPU wrapper.
package nes_cpu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } dma_state_t;

  localparam logic [15:0] OAM_DMA_REG  = 16'h4014;
  localparam logic [15:0] OAM_DATA_REG = 16'h2004;
  localparam int unsigned CPU_CLK_DIV  = 12;

endpackage

// File: rtl/cpu_ce_divider.sv
// CPU clock-enable generator: one-CLK pulse every CLK_DIV master clocks.
module cpu_ce_divider #(
  parameter int unsigned CLK_DIV = 12
) (
  input  logic CLK,
  input  logic RESET_n,
  output logic CE
);

  localparam int unsigned   CntW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q;
  logic            ce_q;

  // First pulse lands on the CLK_DIV-th edge after reset release.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      cnt_q <= '0;
      ce_q  <= 1'b0;
    end else if (cnt_q == CntMax) begin
      cnt_q <= '0;
      ce_q  <= 1'b1;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
      ce_q  <= 1'b0;
    end
  end

  assign CE = ce_q;

endmodule

// File: rtl/cpu_oam_dma_ctrl.sv
// CPU bus front-end: clock-enable generation, sprite-DMA interception and page-copy DMA.
module cpu_oam_dma_ctrl
  import nes_cpu_pkg::*;
#(
  parameter int unsigned CLK_DIV       = CPU_CLK_DIV,
  parameter logic [15:0] DMA_REG_ADDR  = OAM_DMA_REG,
  parameter logic [15:0] DMA_DEST_ADDR = OAM_DATA_REG,
  parameter int unsigned DMA_LEN       = 256
) (
  input  logic        CLK,
  input  logic        RESET_n,
  output logic        CPU_CE,
  output logic        CPU_RDY,
  input  logic [15:0] CPU_ADDR,
  input  logic [7:0]  CPU_DOUT,
  input  logic        CPU_RW_n,
  output logic [7:0]  CPU_DIN,
  output logic [15:0] BUS_ADDR,
  output logic [7:0]  BUS_DOUT,
  output logic        BUS_RW_n,
  input  logic [7:0]  BUS_DIN,
  output logic        DMA_BUSY
);

  localparam logic [7:0] LastIdx = 8'(DMA_LEN - 1);

  dma_state_t state_q;
  logic       parity_q;
  logic       rdy_q;
  logic       busy_q;
  logic [7:0] page_q;
  logic [7:0] index_q;
  logic [7:0] latch_q;
  logic       cpu_ce;

  cpu_ce_divider #(
    .CLK_DIV (CLK_DIV)
  ) u_ce_div (
    .CLK     (CLK),
    .RESET_n (RESET_n),
    .CE      (cpu_ce)
  );

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q  <= IDLE;
      parity_q <= 1'b0;
      rdy_q    <= 1'b1;
      busy_q   <= 1'b0;
      page_q   <= 8'h00;
      index_q  <= 8'h00;
      latch_q  <= 8'h00;
    end else if (cpu_ce) begin
      parity_q <= ~parity_q;
      case (state_q)
        IDLE: begin
          if (!CPU_RW_n && (CPU_ADDR == DMA_REG_ADDR)) begin
            state_q <= HALT;
            page_q  <= CPU_DOUT;
            index_q <= 8'h00;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        // Current get parity means the next cycle is a put: burn it so reads land on gets.
        HALT:  state_q <= parity_q ? READ : ALIGN;
        ALIGN: state_q <= READ;
        READ: begin
          state_q <= WRITE;
          latch_q <= BUS_DIN;
        end
        WRITE: begin
          if (index_q == LastIdx) begin
            state_q <= IDLE;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state_q <= READ;
            index_q <= index_q + 8'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          rdy_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    BUS_ADDR = CPU_ADDR;
    BUS_DOUT = CPU_DOUT;
    BUS_RW_n = CPU_RW_n;
    case (state_q)
      HALT, ALIGN: BUS_RW_n = 1'b1;
      READ: begin
        BUS_ADDR = {page_q, index_q};
        BUS_RW_n = 1'b1;
      end
      WRITE: begin
        BUS_ADDR = DMA_DEST_ADDR;
        BUS_DOUT = latch_q;
        BUS_RW_n = 1'b0;
      end
      default: ;
    endcase
  end

  assign CPU_DIN  = CPU_RW_n ? BUS_DIN : CPU_DOUT;
  assign CPU_CE   = cpu_ce;
  assign CPU_RDY  = rdy_q;
  assign DMA_BUSY = busy_q;

endmodule

// File: tb/tb_cpu_oam_dma_ctrl.sv
// Scoreboard bench: full-length DMA instance (a) and 4-byte instance (b) share CPU stimulus.
module tb_cpu_oam_dma_ctrl;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_rw_n;

  logic        ce_a, rdy_a, bus_rw_a, busy_a;
  logic [7:0]  cpu_din_a, bus_dout_a, bus_din_a;
  logic [15:0] bus_addr_a;
  logic        ce_b, rdy_b, bus_rw_b, busy_b;
  logic [7:0]  cpu_din_b, bus_dout_b, bus_din_b;
  logic [15:0] bus_addr_b;

  wr_t exp_a[$];
  wr_t exp_b[$];
  int  checks = 0;
  int  errors = 0;
  int  ce_cnt = 0;
  int  stall_a = 0;
  int  stall_b = 0;
  int  wr_cnt_a = 0;
  int  abort_left = 0;

  function automatic logic [7:0] ram(input logic [15:0] a);
    if (a == 16'h0123) return 8'hA5;
    if (a[15:8] == 8'h02) return a[7:0];
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  assign bus_din_a = ram(bus_addr_a);
  assign bus_din_b = ram(bus_addr_b);

  cpu_oam_dma_ctrl u_dut_a (
    .CLK      (clk),
    .RESET_n  (rst_n),
    .CPU_CE   (ce_a),
    .CPU_RDY  (rdy_a),
    .CPU_ADDR (cpu_addr),
    .CPU_DOUT (cpu_dout),
    .CPU_RW_n (cpu_rw_n),
    .CPU_DIN  (cpu_din_a),
    .BUS_ADDR (bus_addr_a),
    .BUS_DOUT (bus_dout_a),
    .BUS_RW_n (bus_rw_a),
    .BUS_DIN  (bus_din_a),
    .DMA_BUSY (busy_a)
  );

  cpu_oam_dma_ctrl #(
    .DMA_LEN (4)
  ) u_dut_b (
    .CLK      (clk),
    .RESET_n  (rst_n),
    .CPU_CE   (ce_b),
    .CPU_RDY  (rdy_b),
    .CPU_ADDR (cpu_addr),
    .CPU_DOUT (cpu_dout),
    .CPU_RW_n (cpu_rw_n),
    .CPU_DIN  (cpu_din_b),
    .BUS_ADDR (bus_addr_b),
    .BUS_DOUT (bus_dout_b),
    .BUS_RW_n (bus_rw_b),
    .BUS_DIN  (bus_din_b),
    .DMA_BUSY (busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor for instance a: CE bookkeeping, stall count, DMA write scoreboard.
  initial begin : mon_a
    wr_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ce_cnt = 0;
        if (exp_a.size() != 0) begin
          abort_left = exp_a.size();
          exp_a.delete();
        end
      end else if (ce_a) begin
        ce_cnt++;
        if (!rdy_a) stall_a++;
        if (busy_a && !bus_rw_a) begin
          wr_cnt_a++;
          if (exp_a.size() == 0) begin
            chk("a_unexpected_write", {8'h00, bus_addr_a, bus_dout_a}, 32'hFFFFFFFF);
          end else begin
            e = exp_a.pop_front();
            chk("a_dma_write", {8'h00, bus_addr_a, bus_dout_a}, {8'h00, e});
          end
        end
      end
    end
  end

  initial begin : mon_b
    wr_t e;
    forever begin
      @(negedge clk);
      if (rst_n && ce_b) begin
        if (!rdy_b) stall_b++;
        if (busy_b && !bus_rw_b) begin
          if (exp_b.size() == 0) begin
            chk("b_unexpected_write", {8'h00, bus_addr_b, bus_dout_b}, 32'hFFFFFFFF);
          end else begin
            e = exp_b.pop_front();
            chk("b_dma_write", {8'h00, bus_addr_b, bus_dout_b}, {8'h00, e});
          end
        end
      end
    end
  end

  // Leaves inputs driven inside a CE-high cycle of the requested parity (2 = any).
  task automatic drive_ce(input logic [15:0] a, input logic rw, input logic [7:0] d,
                          input int par);
    bit found = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (ce_a && (par == 2 || (ce_cnt % 2) == par)) begin
        found = 1;
        break;
      end
    end
    if (!found) chk("ce_wait_timeout", 32'd0, 32'd1);
    cpu_addr = a;
    cpu_rw_n = rw;
    cpu_dout = d;
    #1;
  endtask

  task automatic end_cycle();
    @(posedge clk);
    #1;
    cpu_addr = 16'h8000;
    cpu_rw_n = 1'b1;
    cpu_dout = 8'h00;
  endtask

  task automatic push_exp(input logic [7:0] page);
    for (int i = 0; i < 256; i++) exp_a.push_back({16'h2004, ram({page, 8'(i)})});
    for (int i = 0; i < 4; i++) exp_b.push_back({16'h2004, ram({page, 8'(i)})});
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 8000; i++) begin
      @(posedge clk);
      #1;
      if (!busy_a && !busy_b) begin
        done = 1;
        break;
      end
    end
    if (!done) chk("dma_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_dma(input logic [7:0] page, input int par, input int sa, input int sb);
    int s0a, s0b;
    push_exp(page);
    s0a = stall_a;
    s0b = stall_b;
    drive_ce(16'h4014, 1'b0, page, par);
    end_cycle();
    chk("busy_a_rise", 32'(busy_a), 32'd1);
    chk("rdy_a_fall", 32'(rdy_a), 32'd0);
    wait_idle();
    chk("stall_a", 32'(stall_a - s0a), 32'(sa));
    chk("stall_b", 32'(stall_b - s0b), 32'(sb));
    chk("exp_a_drained", 32'(exp_a.size()), 32'd0);
    chk("exp_b_drained", 32'(exp_b.size()), 32'd0);
    chk("rdy_a_back", 32'(rdy_a), 32'd1);
  endtask

  initial begin : stim
    int first, second, nce, base;
    rst_n    = 1'b0;
    cpu_addr = 16'h8000;
    cpu_dout = 8'h00;
    cpu_rw_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ce", 32'(ce_a), 32'd0);
    chk("reset_rdy", 32'(rdy_a), 32'd1);
    chk("reset_busy", 32'(busy_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Divider cadence after reset release
    first = 0;
    second = 0;
    nce = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (ce_a) begin
        nce++;
        if (first == 0) first = i;
        else if (second == 0) second = i;
      end
    end
    chk("ce_first", 32'(first), 32'd12);
    chk("ce_period", 32'(second - first), 32'd12);
    chk("ce_pulses_40", 32'(nce), 32'd3);
    chk("idle_rdy_b", 32'(rdy_b), 32'd1);
    chk("idle_busy_b", 32'(busy_b), 32'd0);

    // IDLE pass-through read and write loopback
    drive_ce(16'h0123, 1'b1, 8'h00, 2);
    chk("rd_bus_addr", 32'(bus_addr_a), 32'h0123);
    chk("rd_bus_rw", 32'(bus_rw_a), 32'd1);
    chk("rd_cpu_din", 32'(cpu_din_a), 32'hA5);
    end_cycle();
    chk("rd_no_stall", 32'(rdy_a), 32'd1);
    drive_ce(16'h0300, 1'b0, 8'h3C, 2);
    chk("wr_bus_rw", 32'(bus_rw_a), 32'd0);
    chk("wr_bus_dout", 32'(bus_dout_a), 32'h3C);
    chk("wr_cpu_din", 32'(cpu_din_a), 32'h3C);
    end_cycle();

    run_dma(8'h02, 0, 513, 9);
    run_dma(8'h03, 1, 514, 10);

    // Abort mid-transfer with asynchronous reset
    push_exp(8'h02);
    base = wr_cnt_a;
    drive_ce(16'h4014, 1'b0, 8'h02, 0);
    end_cycle();
    for (int i = 0; i < 8000; i++) begin
      @(posedge clk);
      if (wr_cnt_a - base >= 100) break;
    end
    chk("abort_reached_100", 32'(wr_cnt_a - base), 32'd100);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_rdy", 32'(rdy_a), 32'd1);
    chk("abort_busy", 32'(busy_a), 32'd0);
    chk("abort_ce", 32'(ce_a), 32'd0);
    chk("abort_bus_rw", 32'(bus_rw_a), 32'd1);
    chk("abort_bus_addr", 32'(bus_addr_a), 32'h8000);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_left", 32'(abort_left), 32'd156);
    chk("abort_b_empty", 32'(exp_b.size()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_dma(8'h04, 0, 513, 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
